// File: rtl/multicycle_core.sv
// Multicycle accumulator-free core: 4 registers, two-word instructions, one shared
// memory port with a req/ack handshake. Every access holds its request until acked.
module multicycle_core #(
    parameter int          DATA_W   = 8,
    parameter int          ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [2:0]        czn,
    output logic              halted
);

    // state    | meaning
    // S_FETCH  | read instruction word at PC
    // S_DECODE | classify opcode held in IR
    // S_FETCH2 | read operand word at PC into TR; resolve jumps
    // S_EXEC   | write ALU/MOV/LDI result and flags
    // S_MEMOP  | LD/ST access at TR
    // S_HALT   | stopped until reset
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_FETCH2, S_EXEC, S_MEMOP, S_HALT
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] regs [4];
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir, tr;
    logic [2:0]        flags;

    logic [3:0]        op;
    logic [1:0]        rd, rs;
    logic              ack;
    logic              jump_taken;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;

    assign op     = ir[DATA_W-1 -: 4];
    assign rd     = ir[3:2];
    assign rs     = ir[1:0];
    assign czn    = flags;
    assign halted = (state == S_HALT);

    // Request is gated by rst so an in-flight access drops the instant reset hits.
    always_comb begin
        mem_req   = ~rst & (state == S_FETCH || state == S_FETCH2 || state == S_MEMOP);
        mem_we    = mem_req & (state == S_MEMOP) & (op == 4'h8);
        mem_addr  = (state == S_MEMOP) ? tr[ADDR_W-1:0] : pc;
        mem_wdata = regs[rd];
    end

    assign ack = mem_req & mem_ack;

    always_comb begin
        sum = '0;
        case (op)
            4'h0: sum = {1'b0, regs[rd]} + {1'b0, regs[rs]};
            4'h1: sum = {1'b0, regs[rd]} + {1'b0, regs[rs]} + {{DATA_W{1'b0}}, flags[2]};
            4'h2: sum = {1'b0, regs[rd]} - {1'b0, regs[rs]};
            4'h3: sum = {1'b0, regs[rd] & regs[rs]};
            4'h4: sum = {1'b0, regs[rd] | regs[rs]};
            4'h5: sum = {1'b0, regs[rs]};
            4'h6: sum = {1'b0, tr};
            default: sum = '0;
        endcase
        alu_res = sum[DATA_W-1:0];
    end

    always_comb begin
        jump_taken = 1'b0;
        case (op)
            4'h9: jump_taken = 1'b1;
            4'hA: jump_taken = flags[1];
            4'hB: jump_taken = flags[2];
            4'hC: jump_taken = flags[0];
            default: jump_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (ack) state_nx = S_DECODE;
            S_DECODE: begin
                if (op <= 4'h5)      state_nx = S_EXEC;
                else if (op <= 4'hC) state_nx = S_FETCH2;
                else if (op == 4'hF) state_nx = S_HALT;
                else                 state_nx = S_FETCH;
            end
            S_FETCH2: begin
                if (ack) begin
                    if (op == 4'h6)                      state_nx = S_EXEC;
                    else if (op == 4'h7 || op == 4'h8)   state_nx = S_MEMOP;
                    else                                 state_nx = S_FETCH;
                end
            end
            S_EXEC:   state_nx = S_FETCH;
            S_MEMOP:  if (ack) state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= ADDR_W'(RESET_PC);
            ir    <= '0;
            tr    <= '0;
            flags <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_FETCH: begin
                    if (ack) begin
                        ir <= mem_rdata;
                        pc <= pc + ADDR_W'(1);
                    end
                end
                S_FETCH2: begin
                    if (ack) begin
                        tr <= mem_rdata;
                        // Target comes straight off the bus: TR loads on this same edge.
                        if (jump_taken) pc <= mem_rdata[ADDR_W-1:0];
                        else            pc <= pc + ADDR_W'(1);
                    end
                end
                S_EXEC: begin
                    regs[rd] <= alu_res;
                    if (op <= 4'h4) flags <= {sum[DATA_W], ~|alu_res, alu_res[DATA_W-1]};
                end
                S_MEMOP: begin
                    if (ack && op == 4'h7) regs[rd] <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: behavioural memory with programmable ack
// latency, and a scoreboard of expected stores popped as the core writes.
module tb_multicycle_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       ack_r = 1'b0;
    logic       spur_ack = 1'b0;
    logic       mem_ack;
    logic [2:0] czn;
    logic       halted;

    assign mem_ack = ack_r | spur_ack;

    always #5 clk = ~clk;

    multicycle_core dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .czn       (czn),
        .halted    (halted)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } st_t;

    logic [7:0] mem [256];
    logic [7:0] prog [$];
    st_t        exp_st_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;

    // 0: zero wait, 1: random 0..2 wait, 2: writes wait 3, 3: read of 0x60 never acks
    int         delay_mode = 0;
    logic       busy = 1'b0;
    int         wait_cnt = 0;
    int         cur_delay = 0;
    int         held = 0;
    logic [7:0] h_addr, h_wdata;
    logic       h_we;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int pick_delay();
        case (delay_mode)
            1: return int'($urandom_range(0, 2));
            2: return mem_we ? 3 : 0;
            3: return (mem_addr == 8'h60 && !mem_we) ? 1000 : 0;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        st_t e;
        ack_r = 1'b0;
        if (rst || !mem_req) begin
            busy = 1'b0;
        end else begin
            if (!busy) begin
                busy      = 1'b1;
                wait_cnt  = 0;
                held      = 0;
                h_addr    = mem_addr;
                h_we      = mem_we;
                h_wdata   = mem_wdata;
                cur_delay = pick_delay();
            end else begin
                check("hold_addr", mem_addr, h_addr);
                check("hold_we", mem_we, h_we);
                if (h_we) check("hold_wdata", mem_wdata, h_wdata);
            end
            held++;
            if (wait_cnt >= cur_delay) begin
                ack_r     = 1'b1;
                mem_rdata = mem[mem_addr];
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    if (exp_st_q.size() == 0) begin
                        check("unexpected_store", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_st_q.pop_front();
                        check("store_addr", mem_addr, e.addr);
                        check("store_data", mem_wdata, e.data);
                    end
                    if (delay_mode == 2) check("store_hold_cycles", held, 4);
                end
                busy = 1'b0;
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input int base);
        for (int i = 0; i < prog.size(); i++) mem[(base + i) % 256] = prog[i];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    // Releases reset just after a rising edge: the rest of that period is cycle 1.
    task automatic release_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check({tag, "_req_after_rst"}, mem_req, 1'b1);
        check({tag, "_we_after_rst"}, mem_we, 1'b0);
        check({tag, "_addr_after_rst"}, mem_addr, 8'h00);
    endtask

    initial begin
        int k;
        clear_mem();
        #2 rst = 1'b1;
        cyc(2);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_czn", czn, 3'b000);
        check("rst_halted", halted, 1'b0);

        // LDI R0,7F; LDI R1,01; ADD R0,R1; ST R0,[40]; HALT
        prog = '{8'h60, 8'h7F, 8'h64, 8'h01, 8'h01, 8'h80, 8'h40, 8'hF0};
        load_prog(0);
        exp_st_q.push_back('{addr: 8'h40, data: 8'h80});
        release_reset("t1");
        cyc(10);
        check("t1_exec_noreq", mem_req, 1'b0);
        check("t1_flags_before_exec", czn, 3'b000);
        cyc(1);
        check("t1_cycle12_fetch", mem_addr, 8'h05);
        check("t1_czn", czn, 3'b001);
        cyc(8);
        check("t1_halted", halted, 1'b1);
        check("t1_drain", exp_st_q.size(), 0);

        // LDI R2,FF; LDI R3,01; ADD R2,R3; JC 20; @20: ST R2,[41]; HALT
        rst = 1'b1;
        clear_mem();
        prog = '{8'h68, 8'hFF, 8'h6C, 8'h01, 8'h0B, 8'hB0, 8'h20};
        load_prog(0);
        prog = '{8'h88, 8'h41, 8'hF0};
        load_prog(8'h20);
        exp_st_q.push_back('{addr: 8'h41, data: 8'h00});
        release_reset("t2");
        cyc(14);
        check("t2_jc_target", mem_addr, 8'h20);
        check("t2_jc_req", mem_req, 1'b1);
        check("t2_czn", czn, 3'b110);
        cyc(10);
        check("t2_halted", halted, 1'b1);
        check("t2_drain", exp_st_q.size(), 0);

        // SUB/ADC/JZ-not-taken/MOV/AND/LD/OR then store all registers, random wait states
        rst = 1'b1;
        clear_mem();
        prog = '{8'h60, 8'h05, 8'h64, 8'h07, 8'h21, 8'h15, 8'hA0, 8'h80,
                 8'h58, 8'h39, 8'h7C, 8'h50, 8'h4F,
                 8'h80, 8'h42, 8'h84, 8'h43, 8'h88, 8'h44, 8'h8C, 8'h45, 8'hF0};
        load_prog(0);
        mem[8'h50] = 8'hA5;
        exp_st_q.push_back('{addr: 8'h42, data: 8'hFE});
        exp_st_q.push_back('{addr: 8'h43, data: 8'h0F});
        exp_st_q.push_back('{addr: 8'h44, data: 8'h0E});
        exp_st_q.push_back('{addr: 8'h45, data: 8'hA5});
        delay_mode = 1;
        release_reset("t3");
        k = 0;
        while (!halted && k < 400) begin
            cyc(1);
            k++;
        end
        check("t3_halted", halted, 1'b1);
        check("t3_czn", czn, 3'b001);
        check("t3_drain", exp_st_q.size(), 0);

        // ST with ack delayed 3 cycles
        rst = 1'b1;
        clear_mem();
        delay_mode = 2;
        prog = '{8'h64, 8'h5A, 8'h84, 8'h30, 8'hF0};
        load_prog(0);
        exp_st_q.push_back('{addr: 8'h30, data: 8'h5A});
        release_reset("t4");
        cyc(7);
        check("t4_st_we", mem_we, 1'b1);
        check("t4_st_addr", mem_addr, 8'h30);
        check("t4_st_wdata", mem_wdata, 8'h5A);
        cyc(3);
        check("t4_st_still_req", mem_req, 1'b1);
        check("t4_st_still_addr", mem_addr, 8'h30);
        cyc(1);
        check("t4_next_fetch", mem_addr, 8'h04);
        check("t4_next_fetch_rd", mem_we, 1'b0);
        cyc(4);
        check("t4_halted", halted, 1'b1);
        check("t4_drain", exp_st_q.size(), 0);

        // JMP FF; NOP at FF wraps PC to 00
        rst = 1'b1;
        clear_mem();
        delay_mode = 0;
        mem[8'h00] = 8'h90;
        mem[8'h01] = 8'hFF;
        mem[8'hFF] = 8'hD0;
        release_reset("t5");
        cyc(3);
        check("t5_jmp_target", mem_addr, 8'hFF);
        cyc(2);
        check("t5_wrap_fetch", mem_addr, 8'h00);
        check("t5_wrap_req", mem_req, 1'b1);

        // Reset during a stalled LD: nothing is written, refetch at 0
        rst = 1'b1;
        clear_mem();
        delay_mode = 3;
        prog = '{8'h68, 8'h11, 8'h78, 8'h60, 8'h88, 8'h46, 8'hF0};
        load_prog(0);
        mem[8'h60] = 8'h99;
        release_reset("t6");
        cyc(8);
        check("t6_ld_req", mem_req, 1'b1);
        check("t6_ld_addr", mem_addr, 8'h60);
        #2 rst = 1'b1;
        #1;
        check("t6_req_drop", mem_req, 1'b0);
        mem[8'h00] = 8'h88;
        mem[8'h01] = 8'h46;
        mem[8'h02] = 8'hF0;
        exp_st_q.push_back('{addr: 8'h46, data: 8'h00});
        delay_mode = 0;
        release_reset("t6b");
        cyc(10);
        check("t6_halted", halted, 1'b1);
        check("t6_drain", exp_st_q.size(), 0);

        // HALT ignores ack pulses; reset restores fetching
        rst = 1'b1;
        clear_mem();
        release_reset("t7");
        cyc(1);
        check("t7_decode_not_halted", halted, 1'b0);
        check("t7_decode_noreq", mem_req, 1'b0);
        cyc(1);
        check("t7_halted", halted, 1'b1);
        spur_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(2);
            check("t7_halt_noreq", mem_req, 1'b0);
            check("t7_halt_stays", halted, 1'b1);
        end
        spur_ack = 1'b0;
        rst = 1'b1;
        #1;
        check("t7_rst_unhalt", halted, 1'b0);
        release_reset("t7b");
        cyc(2);
        check("t7_rehalt", halted, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter DATA_W, default 8, meaning register, ALU and memory word width; legal range 8..32.
REQ-002 Parameter ADDR_W, default 8, meaning PC and memory address width; legal range 4..DATA_W.
REQ-003 Parameter RESET_PC, default 0, meaning PC value loaded at reset.
REQ-004 Port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, meaning asynchronous, active-high reset.
REQ-006 Port mem_req, output, 1, meaning memory transaction request.
REQ-007 Port mem_we, output, 1, meaning write when 1 and read when 0; valid only while mem_req=1.
REQ-008 Port mem_addr, output, ADDR_W, meaning transaction address.
REQ-009 Port mem_wdata, output, DATA_W, meaning store data.
REQ-010 Port mem_rdata, input, DATA_W, meaning read data; sampled in the cycle mem_ack=1.
REQ-011 Port mem_ack, input, 1, meaning transaction complete; ignored while mem_req=0.
REQ-012 Port czn, output, 3, meaning flags {C,Z,N}.
REQ-013 Port halted, output, 1, meaning core stopped by HALT.

Function
REQ-014 The core SHALL contain 4 DATA_W-bit registers R0..R3, a PC, an IR, a TR (operand word) and a flag register.
REQ-015 Instruction word fields SHALL be: op = IR[DATA_W-1:DATA_W-4], rd = IR[3:2], rs = IR[1:0]; the second word of a two-word instruction is latched into TR and its low ADDR_W bits form the address.
REQ-016 Opcodes SHALL be: 0 ADD, 1 ADC (adds C), 2 SUB, 3 AND, 4 OR, 5 MOV rd<-rs, 6 LDI rd<-TR, 7 LD rd<-mem[TR], 8 ST mem[TR]<-rd, 9 JMP, A JZ, B JC, C JN, F HALT; opcodes D and E SHALL execute as NOP (FETCH, DECODE, return).
REQ-017 The FSM SHALL have states FETCH, DECODE, FETCH2, EXEC, MEMOP and HALT; transitions: FETCH->DECODE on ack; DECODE->EXEC for ops 0-5, ->FETCH2 for ops 6-C, ->HALT for F, ->FETCH for D/E; FETCH2->EXEC (6), ->MEMOP (7,8) or ->FETCH (9-C) on ack; EXEC->FETCH; MEMOP->FETCH on ack; HALT is terminal until reset.
REQ-018 Memory handshake: mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable from assertion until the cycle in which mem_ack=1 is sampled; the state SHALL NOT advance before that; with mem_ack tied high every access completes in 1 cycle.
REQ-019 FETCH and FETCH2 SHALL read at PC and increment PC modulo 2^ADDR_W on ack; MEMOP SHALL access address TR[ADDR_W-1:0].
REQ-020 Zero-wait latencies SHALL be: ALU/MOV 3 cycles; LDI, LD, ST 4 cycles; JMP/Jcc 3 cycles; NOP 2 cycles.
REQ-021 ADD/ADC/SUB SHALL update C (carry-out; for SUB, C=1 on borrow), Z (result==0) and N (result MSB); AND/OR SHALL update Z, N and clear C; MOV, LDI, LD, ST and jumps SHALL leave flags unchanged.
REQ-022 Jcc SHALL load PC<-TR[ADDR_W-1:0] when its flag is 1, else PC keeps the post-FETCH2 increment; JMP always loads.
REQ-023 LD SHALL write rd in the cycle mem_ack=1 in MEMOP; results of ops 0-6 SHALL be written in EXEC.
REQ-024 rd==rs SHALL be legal (e.g. ADD R1,R1 doubles R1).
REQ-025 In HALT, mem_req SHALL be 0 and halted SHALL be 1; the first state after DECODE of HALT SHALL be HALT.

Reset
REQ-026 While rst=1, asynchronously: state=FETCH, PC=RESET_PC, R0..R3=0, IR=TR=0, czn=0, halted=0, mem_req=0, mem_we=0.
REQ-027 Reset asserted mid-transaction SHALL drop mem_req in the same cycle; a pending ack SHALL be discarded; no register or memory write SHALL occur.
REQ-028 In the first cycle after rst deasserts, the core SHALL assert mem_req=1, mem_we=0, mem_addr=RESET_PC.

Verification
REQ-029 Defaults, ack tied high, program LDI R0,0x7F; LDI R1,0x01; ADD R0,R1 -> R0=0x80, czn=3'b001, instruction completes on cycle 11 after reset.
REQ-030 LDI R2,0xFF; LDI R3,0x01; ADD R2,R3; JC 0x20 -> R2=0x00, czn=3'b110, next fetch address 0x20.
REQ-031 ST R1,[0x30] with mem_ack delayed 3 cycles -> mem_we=1, mem_addr=0x30, mem_wdata=R1 held constant for 4 cycles; PC unchanged during wait.
REQ-032 PC=0xFF (ADDR_W=8) executing NOP -> next fetch address 0x00.
REQ-033 rst pulsed during LD MEMOP wait -> mem_req low immediately, rd unchanged, refetch at RESET_PC.
REQ-034 HALT -> halted=1, mem_req=0 indefinitely; mem_ack pulses ignored; rst restores fetch.
